// File: rtl/medidor_de_frecuencia.sv
// ============================================================================
// Module   : medidor_de_frecuencia
// Purpose  : Gated frequency meter; counts sig_in rising edges per gate window.
// Revision : 1.0
// ============================================================================
`default_nettype none

module medidor_de_frecuencia #(
    parameter int F_CLK   = 75000000,
    parameter int GATE_HZ = 1,
    parameter int CNT_W   = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sig_in,
    input  logic        start,
    input  logic        cont,
    output logic [26:0] freq,
    output logic        valid,
    output logic        busy,
    output logic        ovf
);

    localparam int              C_G         = F_CLK / GATE_HZ;
    localparam int              C_GW        = (C_G > 1) ? $clog2(C_G) : 1;
    localparam logic [C_GW-1:0] C_GATE_LAST = C_GW'(C_G - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MEASURE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync3;
    logic [C_GW-1:0]  r_gate_cnt;
    logic [CNT_W-1:0] r_edge_cnt;
    logic             r_ovf_flag;
    logic             w_detect;
    logic             w_at_max;
    logic             w_gate_end;
    logic [CNT_W-1:0] w_edge_next;
    logic             w_ovf_next;

    // Two metastability flops plus one delay flop for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_detect    = r_sync2 & ~r_sync3;
    assign w_at_max    = (r_edge_cnt == C_CNT_MAX);
    assign w_edge_next = r_edge_cnt + CNT_W'(w_detect & ~w_at_max);
    assign w_ovf_next  = r_ovf_flag | (w_detect & w_at_max);
    assign w_gate_end  = (r_state == S_MEASURE) && (r_gate_cnt == C_GATE_LAST);

    // Counters are held clear outside MEASURE, so every window starts from zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf_flag <= 1'b0;
        end else if (r_state != S_MEASURE) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf_flag <= 1'b0;
        end else begin
            r_gate_cnt <= r_gate_cnt + C_GW'(1);
            r_edge_cnt <= w_edge_next;
            r_ovf_flag <= w_ovf_next;
        end
    end

    // Result is latched on the last MEASURE edge so it is already stable while valid is high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            freq <= '0;
            ovf  <= 1'b0;
        end else if (w_gate_end) begin
            freq <= 27'(w_edge_next);
            ovf  <= w_ovf_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (start || cont) w_next_state = S_MEASURE;
            S_MEASURE: if (w_gate_end)    w_next_state = S_DONE;
            S_DONE:    w_next_state = cont ? S_MEASURE : S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        valid = 1'b0;
        case (r_state)
            S_MEASURE: busy  = 1'b1;
            S_DONE:    valid = 1'b1;
            default:   ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_medidor_de_frecuencia.sv
// ============================================================================
// Module   : tb_medidor_de_frecuencia
// Purpose  : Self-checking bench for medidor_de_frecuencia against an edge-count model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_medidor_de_frecuencia;

    localparam int G      = 100;
    localparam int SAT_W  = 4;
    localparam int SAT_MX = (1 << SAT_W) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sig_in = 1'b0;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic [26:0] freq, freq2;
    logic        valid, busy, ovf, valid2, busy2, ovf2;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int mode = 0;   // 0 hold, 1 periodic, 2 random, 3 forced high
    int per = 10;
    int ph = 0;
    logic hist [0:16383];

    medidor_de_frecuencia #(.F_CLK(100), .GATE_HZ(1)) dut (
        .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont),
        .freq(freq), .valid(valid), .busy(busy), .ovf(ovf)
    );

    medidor_de_frecuencia #(.F_CLK(100), .GATE_HZ(1), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont),
        .freq(freq2), .valid(valid2), .busy(busy2), .ovf(ovf2)
    );

    always #5 clk = ~clk;

    // What the synchronizer's first flop sees at each rising edge
    always @(posedge clk) begin
        hist[cyc] <= rst ? sig_in : 1'b0;
        cyc       <= cyc + 1;
    end

    initial begin
        forever begin
            @(negedge clk);
            case (mode)
                1: begin
                    sig_in = (ph < per / 2);
                    ph = (ph + 1) % per;
                end
                2: sig_in = 1'($urandom_range(0, 1));
                3: sig_in = 1'b1;
                default: ;
            endcase
        end
    end

    // Window started at edge t counts rises seen by the first flop at edges t-1 .. t+G-2
    function automatic int model_count(input int t);
        int n = 0;
        for (int k = t - 1; k <= t + G - 2; k++)
            if (hist[k] === 1'b1 && hist[k-1] === 1'b0) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_window(input int t, input int restart_at, input int cont_clear_at);
        int nbusy = 0;
        int nvalid = 0;
        int n;
        for (int i = 1; i <= G; i++) begin
            if (busy === 1'b1) nbusy++;
            if (valid !== 1'b0) nvalid++;
            if (i == restart_at) start = 1'b1;
            else if (i == restart_at + 1) start = 1'b0;
            if (i == cont_clear_at) cont = 1'b0;
            @(negedge clk);
        end
        n = model_count(t);
        chk("busy_cycles", nbusy, G);
        chk("valid_in_window", nvalid, 0);
        chk("valid_pulse", {31'd0, valid}, 1);
        chk("busy_in_done", {31'd0, busy}, 0);
        chk("freq", {5'd0, freq}, n);
        chk("ovf", {31'd0, ovf}, 0);
        chk("freq_sat", {5'd0, freq2}, (n > SAT_MX) ? SAT_MX : n);
        chk("ovf_sat", {31'd0, ovf2}, (n > SAT_MX) ? 1 : 0);
    endtask

    task automatic run_single(input int restart_at);
        int t;
        @(negedge clk);
        start = 1'b1;
        t = cyc;
        @(negedge clk);
        start = 1'b0;
        check_window(t, restart_at, 0);
        @(negedge clk);
        chk("valid_after", {31'd0, valid}, 0);
        chk("busy_after", {31'd0, busy}, 0);
    endtask

    initial begin
        int t;
        int idle_bad;

        repeat (3) @(negedge clk);
        chk("rst_freq", {5'd0, freq}, 0);
        chk("rst_valid", {31'd0, valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_ovf", {31'd0, ovf}, 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 0);

        // Period-10 square wave gives exactly ten rises per window
        per = 10;
        ph = $urandom_range(0, 9);
        mode = 1;
        repeat (12) @(negedge clk);
        run_single(0);
        chk("freq_period10", {5'd0, freq}, 10);

        for (int w = 0; w < 3; w++) begin
            if ($urandom_range(0, 1) == 1) begin
                per = $urandom_range(2, 12);
                ph = $urandom_range(0, per - 1);
                mode = 1;
            end else begin
                mode = 2;
            end
            repeat ($urandom_range(3, 15)) @(negedge clk);
            run_single(0);
        end

        // A second start mid-window must not restart it
        mode = 2;
        repeat (5) @(negedge clk);
        run_single(37);

        // Fastest possible input saturates the narrow counter, then a slow window clears ovf
        per = 2;
        ph = 0;
        mode = 1;
        repeat (6) @(negedge clk);
        run_single(0);
        chk("sat_ovf_set", {31'd0, ovf2}, 1);
        per = 10;
        mode = 1;
        repeat (6) @(negedge clk);
        run_single(0);
        chk("sat_ovf_clear", {31'd0, ovf2}, 0);

        // Activity only while idle, constant during the window
        mode = 2;
        repeat (20) @(negedge clk);
        mode = 0;
        repeat (6) @(negedge clk);
        run_single(0);
        chk("freq_quiet", {5'd0, freq}, 0);

        // Continuous mode: back-to-back windows with one DONE cycle between them
        per = 4;
        ph = $urandom_range(0, 3);
        mode = 1;
        repeat (8) @(negedge clk);
        cont = 1'b1;
        t = cyc;
        @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            check_window(t + w * (G + 1), 0, (w == 2) ? 10 : 0);
            @(negedge clk);
        end
        chk("cont_stop_busy", {31'd0, busy}, 0);
        chk("cont_stop_valid", {31'd0, valid}, 0);

        // Reset in the middle of a window aborts it
        mode = 2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        chk("pre_abort_busy", {31'd0, busy}, 1);
        rst = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_valid", {31'd0, valid}, 0);
        chk("abort_freq", {5'd0, freq}, 0);
        chk("abort_ovf", {31'd0, ovf}, 0);
        mode = 3;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle_bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || valid !== 1'b0) idle_bad++;
        end
        chk("post_reset_idle", idle_bad, 0);

        // A level held high through reset release is seen as a single rise
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        t = cyc;
        @(negedge clk);
        start = 1'b0;
        check_window(t, 0, 0);
        chk("release_edge", {5'd0, freq}, 1);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
